// File: rtl/cla_ctrl_pkg.sv
// ============================================================================
// Module   : cla_ctrl_pkg
// Brief    : Shared types and helpers for the nibble-serial CLA sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cla_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla4_slice.sv
// ============================================================================
// Module   : cla4_slice
// Brief    : Combinational 4-bit carry look-ahead adder slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a4 & b4;
    assign w_p = a4 ^ b4;

    // Every carry is a flat sum of products of ci and the generate/propagate terms.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s4 = w_p ^ w_c[3:0];
    assign co = w_c[4];

endmodule

`default_nettype wire

// File: rtl/cla_nibble_serial_ctrl.sv
// ============================================================================
// Module   : cla_nibble_serial_ctrl
// Brief    : WIDTH-bit adder reusing one 4-bit CLA slice, one nibble per clock.
//            Optional macro CLA_CTRL_OVF_EN adds the signed overflow output ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_nibble_serial_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_nibble_serial_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;
    logic [NIB_W-1:0]   w_a4;
    logic [NIB_W-1:0]   w_b4;
    logic [NIB_W-1:0]   w_s4;
    logic               w_co;
    logic               w_last;

    assign w_a4   = r_a[NIB_W*r_idx +: NIB_W];
    assign w_b4   = r_b[NIB_W*r_idx +: NIB_W];
    assign w_last = (r_idx == c_last_idx);

    cla4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register, so reset clears them at once.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[NIB_W*r_idx +: NIB_W] <= w_s4;
                    r_carry <= w_co;
                    if (w_last) r_cout <= w_co;
                    else        r_idx  <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef CLA_CTRL_OVF_EN
    logic r_ovf;

    // The sign bit is only known when the top nibble leaves the slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s4[NIB_W-1] != r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_serial_ctrl.sv
// ============================================================================
// Module   : tb_cla_nibble_serial_ctrl
// Brief    : Directed self-checking bench for cla_nibble_serial_ctrl (WIDTH 32 and 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_nibble_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [31:0] a, b, sum;
    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0]  a8, b8, sum8;
`ifdef CLA_CTRL_OVF_EN
    logic        ovf, ovf8;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef CLA_CTRL_OVF_EN
        , .ovf(ovf)
`endif
    );

    cla_nibble_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef CLA_CTRL_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Launch one operation and return at the first negedge where out_valid is seen.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input bit pulse_run, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (pulse_run && k == 3) begin
                in_valid = 1'b1;
                a = ~av;
                check("in_ready_low_in_run", {63'd0, in_ready}, 64'd0);
            end
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        if (lat < 0) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    vec_t        tbl[6];
    logic [31:0] bb_a[3], bb_b[3];
    logic        bb_c[3];
    logic [32:0] bb_exp;
    int          acc[3];
    int          lat, wr, rd, lat8;

    initial begin
        tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        bb_a[0] = 32'hA5A5_1234; bb_b[0] = 32'h5A5A_EDCB; bb_c[0] = 1'b1;
        bb_a[1] = 32'h89AB_CDEF; bb_b[1] = 32'hFEDC_BA98; bb_c[1] = 1'b0;
        bb_a[2] = 32'h0F0F_F0F0; bb_b[2] = 32'hF0F0_0F10; bb_c[2] = 1'b1;

        rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_in_ready8", {63'd0, in_ready8}, 64'd1);
        rst = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
            check($sformatf("vec%0d_sum", i),  {32'd0, sum},  {32'd0, tbl[i].s});
            check($sformatf("vec%0d_cout", i), {63'd0, cout}, {63'd0, tbl[i].co});
`ifdef CLA_CTRL_OVF_EN
            check($sformatf("vec%0d_ovf", i),  {63'd0, ovf},  {63'd0, tbl[i].ov});
`endif
            @(negedge clk);
            check($sformatf("vec%0d_in_ready_after", i), {63'd0, in_ready}, 64'd1);
            check($sformatf("vec%0d_busy_after", i),     {63'd0, busy},     64'd0);
        end

        // Backpressure with ignored in_valid pulses in RUN and DONE.
        out_ready = 1'b0;
        do_op(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b1, lat);
        check("bp_latency", 64'(lat), 64'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_sum",       {32'd0, sum},       64'hDEAD_BEEF);
            check("bp_cout",      {63'd0, cout},      64'd0);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid",    {63'd0, out_valid}, 64'd0);
        check("bp_release_in_ready", {63'd0, in_ready},  64'd1);

        // Reset while index is 3.
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy",      {63'd0, busy},      64'd0);
        check("mid_rst_sum",       {32'd0, sum},       64'd0);
        check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd5, 32'd7, 1'b0, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd9);
        check("post_rst_sum",  {32'd0, sum},  64'h0000_000C);
        check("post_rst_cout", {63'd0, cout}, 64'd0);

        // Reset while holding a result in DONE drops out_valid immediately.
        @(negedge clk);
        out_ready = 1'b0;
        do_op(32'd1, 32'd2, 1'b0, 1'b0, lat);
        check("done_valid_before_rst", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("done_rst_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Back-to-back with in_valid and out_ready held high.
        wr = 0; rd = 0;
        for (int cyc = 0; cyc < 60 && rd < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                bb_exp = {1'b0, bb_a[rd]} + {1'b0, bb_b[rd]} + {32'd0, bb_c[rd]};
                check($sformatf("b2b%0d_sum", rd),  {32'd0, sum},  {32'd0, bb_exp[31:0]});
                check($sformatf("b2b%0d_cout", rd), {63'd0, cout}, {63'd0, bb_exp[32]});
                rd++;
            end
            if (wr < 3) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    a = bb_a[wr]; b = bb_b[wr]; cin = bb_c[wr];
                    acc[wr] = cyc;
                    wr++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (rd < 3) check("b2b_timeout", 64'd0, 64'd1);
        check("b2b_spacing_01", 64'(acc[1] - acc[0]), 64'd10);
        check("b2b_spacing_12", 64'(acc[2] - acc[1]), 64'd10);

        // Minimum width instance.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'hFF; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        lat8 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid8) begin
                lat8 = k;
                break;
            end
        end
        check("w8_latency", 64'(lat8), 64'd3);
        check("w8_sum",  {56'd0, sum8},  64'd0);
        check("w8_cout", {63'd0, cout8}, 64'd1);
`ifdef CLA_CTRL_OVF_EN
        check("w8_ovf",  {63'd0, ovf8},  64'd0);
`endif
        @(negedge clk);
        check("w8_in_ready_after", {63'd0, in_ready8}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
